// File: rtl/free_list_pkg.sv
// free_list_pkg: shared rename-stage sizes and types for the physical-register
// free list (PRF tag width, free-list pointer width, depth).
package free_list_pkg;

    localparam int PRF_IDX_W    = 6;
    localparam int FL_IDX_W     = 5;
    localparam int FL_DEPTH     = 32;
    localparam int ARCH_REG_NUM = 32;

    typedef logic [PRF_IDX_W-1:0] prf_tag_t;
    typedef logic [FL_IDX_W-1:0]  fl_ptr_t;

    // Free-entry count restored on recovery. The pointer difference wraps
    // modulo the depth; a difference of zero means the list was full, because
    // the snapshot is always taken while at least one tag was free.
    function automatic logic [FL_IDX_W:0] recover_count(input fl_ptr_t diff);
        logic [FL_IDX_W:0] cnt;
        if (diff == {FL_IDX_W{1'b0}}) begin
            cnt = (FL_IDX_W+1)'(FL_DEPTH);
        end else begin
            cnt = {1'b0, diff};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free PRF tags for the R10K-style rename stage.
// Pops hand the head tag to dispatch, pushes take retired old tags from the
// ROB, and a mispredict restores the head pointer from the ROB snapshot.
// Optional build macro FL_DEBUG_EN adds state-observation ports and
// simulation assertions; behaviour is otherwise identical.
module free_list #(
    parameter int FL_DEPTH   = free_list_pkg::FL_DEPTH,
    parameter int FL_IDX_W   = free_list_pkg::FL_IDX_W,
    parameter int PRF_IDX_W  = free_list_pkg::PRF_IDX_W,
    parameter int RESET_BASE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dispatch_en_i,
    input  logic                  rob_head_retire_rdy_i,
    input  logic [PRF_IDX_W-1:0]  rob2fl_tag_i,
    input  logic                  br_recovery_rdy_i,
    input  logic [FL_IDX_W-1:0]   rob2fl_recover_head_i,
    output logic [PRF_IDX_W-1:0]  fl2rob_tag_o,
    output logic [FL_IDX_W-1:0]   fl2rob_cur_head_o,
    output logic                  fl_empty_o
`ifdef FL_DEBUG_EN
    ,
    output logic [FL_IDX_W-1:0]           head_o,
    output logic [FL_IDX_W-1:0]           tail_o,
    output logic [FL_IDX_W:0]             count_o,
    output logic [FL_DEPTH*PRF_IDX_W-1:0] tags_o
`endif
);

    import free_list_pkg::recover_count;

    localparam int CNT_W = FL_IDX_W + 1;

    logic [PRF_IDX_W-1:0] r_tags [FL_DEPTH];
    logic [FL_IDX_W-1:0]  r_head;
    logic [FL_IDX_W-1:0]  r_tail;
    logic [CNT_W-1:0]     r_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic [FL_IDX_W-1:0]  w_tail_nxt;
    logic [FL_IDX_W-1:0]  w_head_nxt;
    logic [CNT_W-1:0]     w_count_nxt;

    assign w_empty = (r_count == {CNT_W{1'b0}});
    assign w_full  = (r_count == CNT_W'(FL_DEPTH));

    // Outputs are read straight from registered state.
    assign fl2rob_tag_o      = r_tags[r_head];
    assign fl2rob_cur_head_o = r_head;
    assign fl_empty_o        = w_empty;

    // Accept decisions: recovery masks pop, and an empty list never bypasses
    // a same-cycle push to the pop side.
    assign w_pop  = dispatch_en_i & ~w_empty & ~br_recovery_rdy_i;
    assign w_push = rob_head_retire_rdy_i & ~w_full;

    // Next-state for pointers and free-entry count.
    always_comb begin
        w_tail_nxt  = r_tail;
        w_head_nxt  = r_head;
        w_count_nxt = r_count;
        if (w_push) begin
            w_tail_nxt = r_tail + FL_IDX_W'(1);
        end else begin
            w_tail_nxt = r_tail;
        end
        if (br_recovery_rdy_i) begin
            w_head_nxt  = rob2fl_recover_head_i;
            w_count_nxt = recover_count(w_tail_nxt - rob2fl_recover_head_i);
        end else if (w_pop) begin
            w_head_nxt  = r_head + FL_IDX_W'(1);
            w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(1);
        end else begin
            w_head_nxt  = r_head;
            w_count_nxt = r_count + CNT_W'(w_push);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {FL_IDX_W{1'b0}};
            r_tail  <= {FL_IDX_W{1'b0}};
            r_count <= CNT_W'(FL_DEPTH);
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Tag storage: reset loads the initial free tags, pushes write at tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_tags[i] <= PRF_IDX_W'(RESET_BASE + i);
            end
        end else if (w_push) begin
            r_tags[r_tail] <= rob2fl_tag_i;
        end
    end

`ifdef FL_DEBUG_EN
    assign head_o  = r_head;
    assign tail_o  = r_tail;
    assign count_o = r_count;

    // Flatten the tag array for observation.
    always_comb begin
        tags_o = {(FL_DEPTH*PRF_IDX_W){1'b0}};
        for (int i = 0; i < FL_DEPTH; i++) begin
            tags_o[i*PRF_IDX_W +: PRF_IDX_W] = r_tags[i];
        end
    end

    logic [FL_IDX_W-1:0] w_popped_since_snap;
    logic [CNT_W+1:0]    w_recover_limit;
    assign w_popped_since_snap = r_head - rob2fl_recover_head_i;
    assign w_recover_limit     = (CNT_W+2)'(r_count) + (CNT_W+2)'(w_popped_since_snap)
                               + (CNT_W+2)'(w_push);

    // Protocol checks on the dispatch/retire/recovery interfaces.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(rob_head_retire_rdy_i && w_full))
                else $error("free_list: push while full");
            assert (!(dispatch_en_i && w_empty))
                else $error("free_list: dispatch while empty");
            assert (!br_recovery_rdy_i || ((CNT_W+2)'(w_count_nxt) <= w_recover_limit))
                else $error("free_list: restored count exceeds popped plus pushed");
        end
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed self-checking bench for free_list (default build).
module tb_free_list;

    logic       clk;
    logic       rst;
    logic       dispatch_en_i;
    logic       rob_head_retire_rdy_i;
    logic [5:0] rob2fl_tag_i;
    logic       br_recovery_rdy_i;
    logic [4:0] rob2fl_recover_head_i;
    logic [5:0] fl2rob_tag_o;
    logic [4:0] fl2rob_cur_head_o;
    logic       fl_empty_o;

    int n_tests = 0;
    int n_fail  = 0;

    free_list dut (
        .clk                   (clk),
        .rst                   (rst),
        .dispatch_en_i         (dispatch_en_i),
        .rob_head_retire_rdy_i (rob_head_retire_rdy_i),
        .rob2fl_tag_i          (rob2fl_tag_i),
        .br_recovery_rdy_i     (br_recovery_rdy_i),
        .rob2fl_recover_head_i (rob2fl_recover_head_i),
        .fl2rob_tag_o          (fl2rob_tag_o),
        .fl2rob_cur_head_o     (fl2rob_cur_head_o),
        .fl_empty_o            (fl_empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
            end
    endtask

    initial begin
        int h;
        int exp_tag;
        rst = 1'b1;
        dispatch_en_i = 1'b0;
        rob_head_retire_rdy_i = 1'b0;
        rob2fl_tag_i = 6'd0;
        br_recovery_rdy_i = 1'b0;
        rob2fl_recover_head_i = 5'd0;
        step();
        step();
        rst = 1'b0;
        chk("rst_tag", 32'(fl2rob_tag_o), 32'd32);
        chk("rst_head", 32'(fl2rob_cur_head_o), 32'd0);
        chk("rst_empty", 32'(fl_empty_o), 32'd0);

        // Three pops from reset.
        dispatch_en_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("pop3_tag", 32'(fl2rob_tag_o), 32'(32 + k));
            step();
        end
        dispatch_en_i = 1'b0;
        chk("pop3_head", 32'(fl2rob_cur_head_o), 32'd3);
        chk("pop3_next_tag", 32'(fl2rob_tag_o), 32'd35);
        chk("pop3_empty", 32'(fl_empty_o), 32'd0);

        // Drain to empty, then a rejected 33rd pop.
        dispatch_en_i = 1'b1;
        for (int k = 3; k < 32; k++) begin
            chk("drain_tag", 32'(fl2rob_tag_o), 32'(32 + k));
            step();
        end
        chk("drain_empty", 32'(fl_empty_o), 32'd1);
        chk("drain_head", 32'(fl2rob_cur_head_o), 32'd0);
        step();
        dispatch_en_i = 1'b0;
        chk("pop33_head", 32'(fl2rob_cur_head_o), 32'd0);
        chk("pop33_empty", 32'(fl_empty_o), 32'd1);

        // Empty plus push: no bypass, pop rejected.
        dispatch_en_i = 1'b1;
        rob_head_retire_rdy_i = 1'b1;
        rob2fl_tag_i = 6'd5;
        step();
        dispatch_en_i = 1'b0;
        rob_head_retire_rdy_i = 1'b0;
        chk("emptypush_head", 32'(fl2rob_cur_head_o), 32'd0);
        chk("emptypush_empty", 32'(fl_empty_o), 32'd0);
        chk("emptypush_tag", 32'(fl2rob_tag_o), 32'd5);

        // Simultaneous pop and push keep the count.
        dispatch_en_i = 1'b1;
        rob_head_retire_rdy_i = 1'b1;
        rob2fl_tag_i = 6'd7;
        step();
        dispatch_en_i = 1'b0;
        rob_head_retire_rdy_i = 1'b0;
        chk("popush_head", 32'(fl2rob_cur_head_o), 32'd1);
        chk("popush_tag", 32'(fl2rob_tag_o), 32'd7);
        chk("popush_empty", 32'(fl_empty_o), 32'd0);
        dispatch_en_i = 1'b1;
        step();
        dispatch_en_i = 1'b0;
        chk("popush_drain_head", 32'(fl2rob_cur_head_o), 32'd2);
        chk("popush_drain_empty", 32'(fl_empty_o), 32'd1);
        chk("popush_drain_tag", 32'(fl2rob_tag_o), 32'd34);

        // Reset mid-operation.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_tag", 32'(fl2rob_tag_o), 32'd32);
        chk("rst2_head", 32'(fl2rob_cur_head_o), 32'd0);
        chk("rst2_empty", 32'(fl_empty_o), 32'd0);

        // Partial recovery: snapshot at head 4, 6 pops, 2 pushes.
        dispatch_en_i = 1'b1;
        repeat (4) step();
        dispatch_en_i = 1'b0;
        chk("snap_head", 32'(fl2rob_cur_head_o), 32'd4);
        chk("snap_tag", 32'(fl2rob_tag_o), 32'd36);
        dispatch_en_i = 1'b1;
        rob_head_retire_rdy_i = 1'b1;
        rob2fl_tag_i = 6'd50;
        step();
        rob2fl_tag_i = 6'd51;
        step();
        rob_head_retire_rdy_i = 1'b0;
        repeat (4) step();
        dispatch_en_i = 1'b0;
        chk("prerec_head", 32'(fl2rob_cur_head_o), 32'd10);
        chk("prerec_tag", 32'(fl2rob_tag_o), 32'd42);
        br_recovery_rdy_i = 1'b1;
        rob2fl_recover_head_i = 5'd4;
        dispatch_en_i = 1'b1;
        step();
        br_recovery_rdy_i = 1'b0;
        dispatch_en_i = 1'b0;
        chk("rec_head", 32'(fl2rob_cur_head_o), 32'd4);
        chk("rec_tag", 32'(fl2rob_tag_o), 32'd36);
        chk("rec_empty", 32'(fl_empty_o), 32'd0);
        // Restored count is (2-4) mod 32 = 30: pop them all.
        dispatch_en_i = 1'b1;
        for (int k = 0; k < 30; k++) begin
            h = (4 + k) % 32;
            exp_tag = (h < 2) ? (50 + h) : (32 + h);
            chk("rec_pop_tag", 32'(fl2rob_tag_o), 32'(exp_tag));
            chk("rec_pop_notempty", 32'(fl_empty_o), 32'd0);
            step();
        end
        dispatch_en_i = 1'b0;
        chk("rec_drain_empty", 32'(fl_empty_o), 32'd1);
        chk("rec_drain_head", 32'(fl2rob_cur_head_o), 32'd2);

        // Recovery with concurrent push: count uses the post-push tail.
        br_recovery_rdy_i = 1'b1;
        rob2fl_recover_head_i = 5'd0;
        rob_head_retire_rdy_i = 1'b1;
        rob2fl_tag_i = 6'd9;
        step();
        br_recovery_rdy_i = 1'b0;
        rob_head_retire_rdy_i = 1'b0;
        chk("recpush_head", 32'(fl2rob_cur_head_o), 32'd0);
        chk("recpush_empty", 32'(fl_empty_o), 32'd0);
        dispatch_en_i = 1'b1;
        chk("recpush_tag0", 32'(fl2rob_tag_o), 32'd50);
        step();
        chk("recpush_tag1", 32'(fl2rob_tag_o), 32'd51);
        step();
        chk("recpush_tag2", 32'(fl2rob_tag_o), 32'd9);
        chk("recpush_notempty", 32'(fl_empty_o), 32'd0);
        step();
        dispatch_en_i = 1'b0;
        chk("recpush_empty_end", 32'(fl_empty_o), 32'd1);
        chk("recpush_head_end", 32'(fl2rob_cur_head_o), 32'd3);

        // Full-count recovery: 32 pops, restore head 0, count is 32.
        rst = 1'b1;
        step();
        rst = 1'b0;
        dispatch_en_i = 1'b1;
        repeat (32) step();
        dispatch_en_i = 1'b0;
        chk("full_pre_empty", 32'(fl_empty_o), 32'd1);
        br_recovery_rdy_i = 1'b1;
        rob2fl_recover_head_i = 5'd0;
        step();
        br_recovery_rdy_i = 1'b0;
        chk("full_rec_empty", 32'(fl_empty_o), 32'd0);
        chk("full_rec_tag", 32'(fl2rob_tag_o), 32'd32);
        chk("full_rec_head", 32'(fl2rob_cur_head_o), 32'd0);
        // A push while full is dropped.
        rob_head_retire_rdy_i = 1'b1;
        rob2fl_tag_i = 6'd1;
        step();
        rob_head_retire_rdy_i = 1'b0;
        chk("fullpush_tag", 32'(fl2rob_tag_o), 32'd32);
        chk("fullpush_head", 32'(fl2rob_cur_head_o), 32'd0);
        dispatch_en_i = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk("full_pop_tag", 32'(fl2rob_tag_o), 32'(32 + k));
            chk("full_pop_notempty", 32'(fl_empty_o), 32'd0);
            step();
        end
        dispatch_en_i = 1'b0;
        chk("full_pop_empty", 32'(fl_empty_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
